// File: rtl/ram_resp_ctrl.sv
// Word-addressed storage responder for the wr/rd strobe interface.
// Zero-clears the array after reset, then serves 1-cycle reads with write-first forwarding.
module ram_resp_ctrl #(
  parameter int WORD_WIDTH  = 32,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_i,
  input  logic [INDEX_WIDTH-1:0] wr_index_i,
  input  logic [WORD_WIDTH-1:0]  wr_data_i,
  output logic                   wr_ack_o,
  input  logic                   rd_i,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  output logic [WORD_WIDTH-1:0]  rd_data_o,
  output logic                   rd_valid_o,
  output logic                   ready_o,
  output logic                   err_o
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] clr_idx;
  logic [WORD_WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= INIT;
      clr_idx    <= '0;
      ready_o    <= 1'b0;
      wr_ack_o   <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      wr_ack_o   <= 1'b0;
      rd_valid_o <= 1'b0;
      case (state)
        INIT: begin
          clr_idx <= clr_idx + 1'b1;
          // The last clear and the transition share one edge, so READY follows DEPTH clears.
          if (clr_idx == '1) begin
            state   <= READY;
            ready_o <= 1'b1;
          end
          if (wr_i || rd_i) err_o <= 1'b1;
        end
        READY: begin
          wr_ack_o   <= wr_i;
          rd_valid_o <= rd_i;
          if (rd_i) begin
            if (wr_i && (wr_index_i == rd_index_i)) rd_data_o <= wr_data_i;
            else                                    rd_data_o <= mem[rd_index_i];
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Storage has no reset of its own; the INIT sweep is what zeroes it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == INIT)  mem[clr_idx]    <= '0;
      else if (wr_i)      mem[wr_index_i] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_ram_resp_ctrl.sv
// Bench for ram_resp_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (array + init countdown) checked after every edge.
module tb_ram_resp_ctrl;
  localparam int WW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wr, rd;
  logic [IW-1:0] wr_index, rd_index;
  logic [WW-1:0] wr_data;
  logic          wr_ack, rd_valid, ready, err;
  logic [WW-1:0] rd_data;

  ram_resp_ctrl #(.WORD_WIDTH(WW), .INDEX_WIDTH(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_i(wr), .wr_index_i(wr_index), .wr_data_i(wr_data), .wr_ack_o(wr_ack),
    .rd_i(rd), .rd_index_i(rd_index), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .ready_o(ready), .err_o(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: the array as the initiator would see it, plus cycles of clearing done.
  logic [WW-1:0] m_mem [DEPTH];
  int            m_clear_cycles;
  logic          m_ready, m_ack, m_valid, m_err;
  logic [WW-1:0] m_rdata;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [IW-1:0] wi,
                            input logic [WW-1:0] wd, input logic rq, input logic [IW-1:0] ri);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_clear_cycles = 0;
      m_ready = 0; m_ack = 0; m_valid = 0; m_err = 0; m_rdata = '0;
    end else if (!m_ready) begin
      m_ack = 0; m_valid = 0;
      if (w || rq) m_err = 1;
      m_clear_cycles++;
      if (m_clear_cycles == DEPTH) m_ready = 1;
    end else begin
      m_ack   = w;
      m_valid = rq;
      if (rq) m_rdata = (w && wi == ri) ? wd : m_mem[ri];
      if (w) m_mem[wi] = wd;
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [IW-1:0] wi,
                       input logic [WW-1:0] wd, input logic rq, input logic [IW-1:0] ri);
    rst = r; wr = w; wr_index = wi; wr_data = wd; rd = rq; rd_index = ri;
    @(posedge clk);
    model_edge(r, w, wi, wd, rq, ri);
    #1;
    check("ready",    {31'b0, ready},    {31'b0, m_ready});
    check("wr_ack",   {31'b0, wr_ack},   {31'b0, m_ack});
    check("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
    check("err",      {31'b0, err},      {31'b0, m_err});
    check("rd_data",  rd_data,           m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    cycle(1, 0, '0, '0, 0, '0);
    cycle(1, 0, '0, '0, 0, '0);
  endtask

  initial begin
    rst = 1; wr = 0; rd = 0; wr_index = '0; rd_index = '0; wr_data = '0;
    m_clear_cycles = 0; m_ready = 0; m_ack = 0; m_valid = 0; m_err = 0; m_rdata = '0;

    // Reset then idle: 15 cycles not ready, ready after the 16th clear.
    do_reset();
    check("lit_rst_ready", {31'b0, ready}, 32'd0);
    check("lit_rst_data",  rd_data, 32'd0);
    idle(15);
    check("lit_init15_ready", {31'b0, ready}, 32'd0);
    idle(1);
    check("lit_init16_ready", {31'b0, ready}, 32'd1);
    check("lit_init_err",     {31'b0, err},   32'd0);

    // Write then read.
    cycle(0, 1, 4'd1, 32'h5, 0, '0);
    check("lit_wr_ack", {31'b0, wr_ack}, 32'd1);
    cycle(0, 0, '0, '0, 1, 4'd1);
    check("lit_rd1", rd_data, 32'h5);
    check("lit_rd1_valid", {31'b0, rd_valid}, 32'd1);
    cycle(0, 0, '0, '0, 1, 4'd2);
    check("lit_rd2", rd_data, 32'h0);

    // Overwrite and hold.
    cycle(0, 1, 4'd1, 32'h7, 0, '0);
    cycle(0, 0, '0, '0, 1, 4'd1);
    check("lit_overwrite", rd_data, 32'h7);
    idle(3);
    check("lit_hold_data",  rd_data, 32'h7);
    check("lit_hold_valid", {31'b0, rd_valid}, 32'd0);

    // Simultaneous access.
    cycle(0, 1, 4'd3, 32'hA, 1, 4'd3);
    check("lit_fwd_same", rd_data, 32'hA);
    cycle(0, 1, 4'd4, 32'hB, 1, 4'd5);
    check("lit_fwd_diff", rd_data, 32'h0);

    // Strobe during INIT at init cycle 3.
    do_reset();
    idle(2);
    cycle(0, 1, 4'd0, 32'hF, 0, '0);
    check("lit_init_wr_ack", {31'b0, wr_ack}, 32'd0);
    check("lit_init_wr_err", {31'b0, err},    32'd1);
    idle(13);
    cycle(0, 0, '0, '0, 1, 4'd0);
    check("lit_init_wr_rd0", rd_data, 32'h0);
    check("lit_err_sticky",  {31'b0, err}, 32'd1);

    // Strobe on last INIT edge is ignored; first READY edge is accepted.
    do_reset();
    idle(15);
    cycle(0, 1, 4'd2, 32'h33, 0, '0);
    check("lit_last_init_ack", {31'b0, wr_ack}, 32'd0);
    check("lit_last_init_err", {31'b0, err},    32'd1);
    cycle(0, 1, 4'd2, 32'h44, 0, '0);
    check("lit_first_ready_ack", {31'b0, wr_ack}, 32'd1);
    cycle(0, 0, '0, '0, 1, 4'd2);
    check("lit_first_ready_rd", rd_data, 32'h44);

    // Reset mid-operation, concurrent with a read.
    cycle(0, 1, 4'd6, 32'h9, 0, '0);
    cycle(1, 0, '0, '0, 1, 4'd6);
    check("lit_midrst_valid", {31'b0, rd_valid}, 32'd0);
    check("lit_midrst_err",   {31'b0, err},      32'd0);
    idle(16);
    cycle(0, 0, '0, '0, 1, 4'd6);
    check("lit_midrst_rd6", rd_data, 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic          r, w, q;
      logic [IW-1:0] wi, ri;
      logic [WW-1:0] wd;
      r  = ($urandom_range(0, 249) == 0);
      w  = ($urandom_range(0, 1) == 1);
      q  = ($urandom_range(0, 1) == 1);
      wi = IW'($urandom_range(0, DEPTH - 1));
      ri = ($urandom_range(0, 3) == 0) ? wi : IW'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      if ($urandom_range(0, 9) < 3 && !m_ready) begin
        w = 0; q = 0;
      end
      cycle(r, w, wi, wd, q, ri);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_resp_ctrl.md
# ram_resp_ctrl

Responder for the single-cycle wr/rd strobe memory interface that the SoC bench and future core-side initiators drive. It owns a DEPTH = 2^INDEX_WIDTH word storage array and zero-clears it after every reset. It performs strobed writes and reads, returning read data one cycle later with a valid flag and same-cycle write-to-read forwarding. It sits directly behind any initiator of that interface inside the SoC top.

## Interface
- WORD_WIDTH, 32, data word width in bits
- INDEX_WIDTH, 4, word index width; DEPTH = 2^INDEX_WIDTH words
- clk_i  in  1  single clock; all logic rising-edge
- rst_i  in  1  reset, synchronous, active-high
- wr_i  in  1  write strobe, sampled each rising edge
- wr_index_i  in  INDEX_WIDTH  write word index
- wr_data_i  in  WORD_WIDTH  write data
- wr_ack_o  out  1  one-cycle pulse: the write sampled on the previous edge was performed
- rd_i  in  1  read strobe, sampled each rising edge
- rd_index_i  in  INDEX_WIDTH  read word index
- rd_data_o  out  WORD_WIDTH  registered read data
- rd_valid_o  out  1  one-cycle pulse: rd_data_o holds the result of the read sampled on the previous edge
- ready_o  out  1  high when requests are accepted (state READY)
- err_o  out  1  sticky: a strobe arrived while ready_o = 0

## Operation
- FSM states: INIT, READY.
- rst_i high at an edge forces INIT and sets clr_idx = 0. Every register, outputs included, takes its reset value.
- INIT: each cycle writes 0 to word clr_idx, then increments clr_idx.
  - When clr_idx = DEPTH-1 has been written, the FSM goes to READY on the same edge.
  - clr_idx wraps to 0 and has no further effect.
- READY: wr_i = 1 writes wr_data_i to word wr_index_i and pulses wr_ack_o.
- READY: rd_i = 1 loads rd_data_o with word rd_index_i and pulses rd_valid_o.
- wr_i and rd_i high together: both are performed.
  - Same index: the read returns the new wr_data_i (write-first forwarding).
  - Different index: the read returns the stored word.
- No read in a cycle: rd_data_o holds its last value and rd_valid_o = 0.
- Strobes while in INIT:
  - Ignored: no array change, no ack, no valid.
  - err_o is set and stays at 1 until rst_i.
- wr_i and rd_i are independent. Neither has priority or stalls the other. There is no back-pressure beyond ready_o.
- Index range: all indices are legal because DEPTH = 2^INDEX_WIDTH, so no bounds check is needed.

## Timing
- Reset values: ready_o = 0, wr_ack_o = 0, rd_valid_o = 0, rd_data_o = 0, err_o = 0.
- Init duration: rst_i is sampled low at edge E0. ready_o rises after edge E0+DEPTH-1, i.e. DEPTH cycles of clearing (16 for the default parameters).
- Read latency is 1: rd_i sampled at edge N gives rd_data_o and rd_valid_o valid after edge N, observed before edge N+1.
- Write latency is 1: wr_i sampled at edge N gives wr_ack_o high after N. A read sampled at N+1 or later observes the written data.
- Back-to-back strobes on consecutive edges are accepted at full rate, one per port per cycle.
- Reset mid-operation: takes effect at the next edge.
  - Pending ack/valid pulses are dropped.
  - The clear sweep restarts at index 0.
  - Array contents are zero once INIT completes.
- A strobe at the last INIT edge (ready_o still 0) is ignored and sets err_o.
- A strobe at the first edge with ready_o = 1 is accepted.

## Test plan
- Reset then idle: rst_i for 2 cycles, then low.
  - ready_o = 0 for exactly 16 cycles, then 1.
  - All outputs 0 throughout; err_o stays 0.
- Write then read:
  - wr idx 1 data 0x5 gives wr_ack_o the next cycle.
  - rd idx 1 gives rd_data_o = 0x5 with rd_valid_o next cycle.
  - rd idx 2 gives 0x0 (cleared).
- Overwrite: wr idx 1 = 0x7, then rd idx 1 gives 0x7. rd_data_o holds 0x7 through following idle cycles with rd_valid_o = 0.
- Simultaneous access:
  - Same cycle wr idx 3 = 0xA and rd idx 3 gives rd_data_o = 0xA.
  - Same cycle wr idx 4 = 0xB and rd idx 5 gives the prior idx 5 value (0x0).
- Strobe during INIT: wr idx 0 = 0xF at init cycle 3.
  - err_o = 1 and stays 1; no wr_ack_o.
  - After ready, rd idx 0 gives 0x0.
- Reset mid-op: write idx 6 = 0x9, then pulse rst_i concurrently with rd_i.
  - No rd_valid_o; err_o clears.
  - After a fresh 16-cycle INIT, rd idx 6 gives 0x0.
